// File: rtl/snake_irq_pkg.sv
// Shared constants for the snake SoC interrupt aggregator: register map
// and vector register layout.
package snake_irq_pkg;

    localparam int MAX_IRQ       = 16;
    localparam int VEC_VALID_BIT = 15;

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] ADDR_MODE    = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [2:0] ADDR_VECTOR  = 3'd4;
    localparam logic [2:0] ADDR_SET     = 3'd5;
    localparam logic [2:0] ADDR_RAW     = 3'd6;

endpackage

// File: rtl/snake_irq_prio_enc.sv
// Lowest-index-wins priority encoder; index is 0 when nothing is requested.
module snake_irq_prio_enc #(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [3:0]         index,
    output logic               valid
);

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        index = 4'd0;
        valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_irq_ctrl.sv
// Avalon-MM interrupt aggregator: level/edge latching, masking, priority
// vector and a single registered irq to the CPU.
module snake_irq_ctrl
    import snake_irq_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq
);

    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [15:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d;

    logic               wr_en, we_pend, we_enable, we_mode, we_set;
    logic [NUM_IRQ-1:0] wd, mode_chg, edge_set, edge_clr, edge_next, active;
    logic [3:0]         vec_index;
    logic               vec_valid;
    logic [15:0]        vector;
    logic               unused_wd;

    function automatic logic [MAX_IRQ-1:0] zext(input logic [NUM_IRQ-1:0] v);
        logic [MAX_IRQ-1:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

    assign unused_wd = ^writedata;
    assign wd        = writedata[NUM_IRQ-1:0];
    assign active    = pending_q & enable_q;

    snake_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
        .req   (active),
        .index (vec_index),
        .valid (vec_valid)
    );

    always_comb begin
        wr_en     = chipselect & ~write_n;
        we_pend   = wr_en && (address == ADDR_PENDING);
        we_enable = wr_en && (address == ADDR_ENABLE);
        we_mode   = wr_en && (address == ADDR_MODE);
        we_set    = wr_en && (address == ADDR_SET);

        enable_d   = we_enable ? wd : enable_q;
        mode_d     = we_mode ? wd : mode_q;
        irq_prev_d = irq_in;

        // Edge sources: set beats clear; any mode change forces pending low.
        mode_chg  = we_mode ? (wd ^ mode_q) : '0;
        edge_set  = (irq_in & ~irq_prev_q) | (we_set ? wd : '0);
        edge_clr  = we_pend ? wd : '0;
        edge_next = edge_set | (pending_q & ~edge_clr);
        pending_d = ~mode_chg & ((mode_q & edge_next) | (~mode_q & irq_in));

        irq_d = |active;

        vector                = '0;
        vector[VEC_VALID_BIT] = vec_valid;
        vector[3:0]           = vec_index;

        case (address)
            ADDR_PENDING: readdata_d = zext(pending_q);
            ADDR_ENABLE:  readdata_d = zext(enable_q);
            ADDR_MODE:    readdata_d = zext(mode_q);
            ADDR_ACTIVE:  readdata_d = zext(active);
            ADDR_VECTOR:  readdata_d = vector;
            ADDR_RAW:     readdata_d = zext(irq_prev_q);
            default:      readdata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            irq_prev_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            irq_prev_q <= irq_prev_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_snake_irq_ctrl.sv
// Directed bench for snake_irq_ctrl: requests are issued on the falling edge,
// expectations queued, and a monitor compares just after the rising edge.
module tb_snake_irq_ctrl;
    import snake_irq_pkg::*;

    localparam int NUM_IRQ = 8;

    logic               clk;
    logic               reset_n;
    logic [NUM_IRQ-1:0] irq_in;
    logic [2:0]         address;
    logic               chipselect;
    logic               write_n;
    logic [15:0]        writedata;
    logic [15:0]        readdata;
    logic               irq;

    snake_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_in     (irq_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    string       name_q[$];
    logic        irq_exp_q[$];
    string       irq_name_q[$];
    logic        rd_issue = 1'b0;
    logic        irq_probe = 1'b0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin : monitor
        logic        rd_f, ip_f;
        logic [15:0] e;
        logic        ei;
        string       n;
        rd_f = rd_issue;
        ip_f = irq_probe;
        #1;
        if (rd_f) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_queue: got empty queue expected an entry");
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check16(n, readdata, e);
            end
        end
        if (ip_f) begin
            if (irq_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL irq_queue: got empty queue expected an entry");
            end else begin
                ei = irq_exp_q.pop_front();
                n  = irq_name_q.pop_front();
                check16(n, {15'd0, irq}, {15'd0, ei});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next();
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd_issue   = 1'b0;
        irq_probe  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        next();
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        rd_issue   = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        next();
    endtask

    task automatic wr_rd(input logic [2:0] a, input logic [15:0] d, input logic [15:0] exp,
                         input string name);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        rd_issue   = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        next();
    endtask

    // Probe value of irq after the coming rising edge; does not advance time.
    task automatic irq_chk(input logic exp, input string name);
        irq_probe = 1'b1;
        irq_exp_q.push_back(exp);
        irq_name_q.push_back(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n    = 1'b0;
        irq_in     = 8'h01;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        repeat (2) @(negedge clk);

        irq_chk(1'b0, "rst_irq");
        rd(ADDR_PENDING, 16'h0000, "rst_readdata");

        reset_n = 1'b1;
        next();
        rd(ADDR_PENDING, 16'h0001, "rel_pending");
        rd(ADDR_RAW, 16'h0001, "rel_raw");
        irq_chk(1'b0, "rel_irq");
        rd(ADDR_ACTIVE, 16'h0000, "rel_active");

        // Timer path, level source 0
        irq_in = 8'h00;
        next();
        wr(ADDR_ENABLE, 16'h0001);
        wr(ADDR_MODE, 16'h0000);
        irq_in = 8'h01;
        irq_chk(1'b0, "tmr_lat1");
        next();
        irq_chk(1'b1, "tmr_lat2");
        rd(ADDR_VECTOR, 16'h8000, "tmr_vector");
        irq_in = 8'h00;
        irq_chk(1'b1, "tmr_fall1");
        next();
        irq_chk(1'b0, "tmr_fall2");
        next();

        // Edge source 2
        wr(ADDR_MODE, 16'h0004);
        wr(ADDR_ENABLE, 16'h0004);
        irq_in = 8'h04;
        next();
        irq_in = 8'h00;
        next();
        irq_chk(1'b1, "edge_irq");
        rd(ADDR_PENDING, 16'h0004, "edge_pending");
        irq_chk(1'b1, "edge_w1c_lat1");
        wr(ADDR_PENDING, 16'h0004);
        irq_chk(1'b0, "edge_w1c_lat2");
        rd(ADDR_PENDING, 16'h0000, "edge_cleared");

        // SET, W1C and set/clear collision on edge source 3
        wr(ADDR_MODE, 16'h000C);
        wr(ADDR_SET, 16'h0008);
        rd(ADDR_PENDING, 16'h0008, "set_bit3");
        wr(ADDR_SET, 16'h0010);
        rd(ADDR_PENDING, 16'h0008, "set_level_ignored");
        wr(ADDR_PENDING, 16'h0008);
        rd(ADDR_PENDING, 16'h0000, "w1c_bit3");
        irq_in = 8'h08;
        wr(ADDR_PENDING, 16'h0008);
        irq_in = 8'h00;
        rd(ADDR_PENDING, 16'h0008, "collision_set_wins");
        wr(ADDR_PENDING, 16'h0008);

        // Priority between sources 5 and 2
        wr(ADDR_MODE, 16'h0024);
        wr(ADDR_ENABLE, 16'h0024);
        wr(ADDR_SET, 16'h0024);
        rd(ADDR_ACTIVE, 16'h0024, "prio_active");
        rd(ADDR_VECTOR, 16'h8002, "prio_vec_2");
        rd(ADDR_SET, 16'h0000, "set_reads_zero");
        rd(3'd7, 16'h0000, "reserved_reads_zero");
        wr(ADDR_PENDING, 16'h0004);
        rd(ADDR_VECTOR, 16'h8005, "prio_vec_5");
        wr(ADDR_PENDING, 16'h0020);
        rd(ADDR_VECTOR, 16'h0000, "prio_vec_none");

        // Mode switch on pending edge source 4
        wr(ADDR_MODE, 16'h0010);
        wr_rd(ADDR_ENABLE, 16'h0010, 16'h0024, "enable_prewrite");
        wr(ADDR_SET, 16'h0010);
        irq_chk(1'b1, "msw_irq_on");
        rd(ADDR_PENDING, 16'h0010, "msw_pending");
        irq_chk(1'b1, "msw_irq_lat1");
        wr(ADDR_MODE, 16'h0000);
        irq_chk(1'b0, "msw_irq_off");
        rd(ADDR_PENDING, 16'h0000, "msw_pending_clr");

        // Asynchronous reset mid-operation
        irq_in = 8'h01;
        wr(ADDR_ENABLE, 16'h00FF);
        next();
        irq_chk(1'b1, "pre_rst_irq");
        rd(ADDR_ENABLE, 16'h00FF, "pre_rst_enable");
        reset_n = 1'b0;
        #1;
        check16("async_rst_readdata", readdata, 16'h0000);
        check16("async_rst_irq", {15'd0, irq}, 16'h0000);
        next();
        reset_n = 1'b1;
        next();
        rd(ADDR_ENABLE, 16'h0000, "post_rst_enable");
        irq_chk(1'b0, "post_rst_irq");
        rd(ADDR_PENDING, 16'h0001, "post_rst_pending");
        next();

        checks++;
        if (exp_q.size() != 0 || irq_exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d/%0d left expected 0/0",
                     exp_q.size(), irq_exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
